// File: rtl/game_loop_ctrl.sv
// rtl/game_loop_ctrl.sv - runner game-loop FSM, frame strobe, speed ramp and cooldowns (optional pause: GAME_LOOP_CTRL_PAUSE_EN)
module game_loop_ctrl #(
    parameter int FPS            = 60,
    parameter int SPEED_W        = 15,
    parameter int SPEED_INIT     = 6144,
    parameter int SPEED_MAX      = 13312,
    parameter int ACCEL          = 1,
    parameter int CLEAR_FRAMES   = 180,
    parameter int RESTART_FRAMES = 45,
    parameter int HIT_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     painter_finished,
    input  logic                     jump,
    input  logic                     pause_req,
    input  logic [HIT_W-1:0]         hit,
    output logic                     update,
    output logic [$clog2(FPS)-1:0]   timer,
    output logic [1:0]               state,
    output logic [SPEED_W-1:0]       speed,
    output logic                     start,
    output logic                     has_obstacles,
    output logic                     game_reset,
    output logic                     rng_load
);

    localparam int TIMER_W = $clog2(FPS);
    localparam int CLR_W   = $clog2(CLEAR_FRAMES + 2);
    localparam int COOL_W  = (RESTART_FRAMES < 1) ? 1 : $clog2(RESTART_FRAMES + 1);

`ifdef GAME_LOOP_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam logic [SPEED_W:0]   SPEED_MAX_X  = (SPEED_W+1)'(SPEED_MAX);
    localparam logic [SPEED_W:0]   ACCEL_X      = (SPEED_W+1)'(ACCEL);
    localparam logic [SPEED_W-1:0] SPEED_INIT_V = SPEED_W'(SPEED_INIT);
    localparam logic [CLR_W-1:0]   CLR_LIMIT    = CLR_W'(CLEAR_FRAMES);
    localparam logic [CLR_W-1:0]   CLR_SAT      = CLR_W'(CLEAR_FRAMES + 1);
    localparam logic [COOL_W-1:0]  COOL_SAT     = COOL_W'(RESTART_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(FPS - 1);

    typedef enum logic [1:0] {
        ST_WAITING = 2'd0,
        ST_RUNNING = 2'd1,
        ST_CRASHED = 2'd2,
        ST_PAUSED  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                pf_last;
    logic [CLR_W-1:0]    clr_cnt, clr_cnt_d, clr_inc;
    logic [COOL_W-1:0]   cool_cnt, cool_cnt_d, cool_inc;
    logic [SPEED_W-1:0]  speed_d, speed_step;
    logic [SPEED_W:0]    speed_sum;
    logic                start_d, has_obstacles_d, rng_load_d, game_reset_d;
    logic                frame_edge, hit_any, timer_adv;

    assign frame_edge = painter_finished & ~pf_last;
    assign hit_any    = |hit;
    assign timer_adv  = frame_edge & ~(PAUSE_EN & (state_q == ST_PAUSED));

    // One extra bit on the sum so a step near the top of the range cannot wrap before the clamp.
    assign speed_sum  = {1'b0, speed} + ACCEL_X;
    assign speed_step = (speed_sum > SPEED_MAX_X) ? SPEED_MAX_X[SPEED_W-1:0] : speed_sum[SPEED_W-1:0];
    assign clr_inc    = (clr_cnt >= CLR_SAT) ? CLR_SAT : clr_cnt + CLR_W'(1);
    assign cool_inc   = (cool_cnt >= COOL_SAT) ? COOL_SAT : cool_cnt + COOL_W'(1);

    assign state = state_q;

    // Next-state and datapath decisions; everything except a crash waits for the frame strobe.
    always_comb begin
        state_d         = state_q;
        speed_d         = speed;
        start_d         = start;
        has_obstacles_d = has_obstacles;
        rng_load_d      = rng_load;
        clr_cnt_d       = clr_cnt;
        cool_cnt_d      = cool_cnt;
        game_reset_d    = 1'b0;
        case (state_q)
            ST_WAITING: begin
                if (update && jump) begin
                    state_d    = ST_RUNNING;
                    speed_d    = SPEED_INIT_V;
                    start_d    = 1'b1;
                    rng_load_d = 1'b0;
                    clr_cnt_d  = '0;
                end
            end
            ST_RUNNING: begin
                if (hit_any) begin
                    state_d    = ST_CRASHED;
                    cool_cnt_d = '0;
                end else if (update && PAUSE_EN && pause_req) begin
                    state_d = ST_PAUSED;
                end else if (update) begin
                    speed_d         = speed_step;
                    clr_cnt_d       = clr_inc;
                    has_obstacles_d = (clr_inc > CLR_LIMIT);
                end
            end
            ST_PAUSED: begin
                if (update && !pause_req) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_CRASHED: begin
                if (update) begin
                    cool_cnt_d = cool_inc;
                    // The update that completes the cooldown may itself carry the restart jump.
                    if ((cool_inc == COOL_SAT) && jump) begin
                        state_d         = ST_RUNNING;
                        game_reset_d    = 1'b1;
                        speed_d         = SPEED_INIT_V;
                        has_obstacles_d = 1'b0;
                        clr_cnt_d       = '0;
                        cool_cnt_d      = '0;
                    end
                end
            end
            default: state_d = ST_WAITING;
        endcase
    end

    // State, strobe, timer and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_WAITING;
            pf_last       <= 1'b0;
            update        <= 1'b0;
            timer         <= '0;
            speed         <= '0;
            start         <= 1'b0;
            has_obstacles <= 1'b0;
            game_reset    <= 1'b0;
            rng_load      <= 1'b1;
            clr_cnt       <= '0;
            cool_cnt      <= '0;
        end else begin
            state_q       <= state_d;
            pf_last       <= painter_finished;
            update        <= frame_edge;
            if (timer_adv) begin
                timer <= (timer == TIMER_LAST) ? '0 : timer + TIMER_W'(1);
            end
            speed         <= speed_d;
            start         <= start_d;
            has_obstacles <= has_obstacles_d;
            game_reset    <= game_reset_d;
            rng_load      <= rng_load_d;
            clr_cnt       <= clr_cnt_d;
            cool_cnt      <= cool_cnt_d;
        end
    end

endmodule

// File: tb/tb_game_loop_ctrl.sv
// tb/tb_game_loop_ctrl.sv - randomized and directed bench for game_loop_ctrl against a frame-level model
module tb_game_loop_ctrl;

    localparam int FPS = 60;
    localparam int TW = $clog2(FPS);
    localparam int HIT_W = 16;
    localparam int SPEED_MAX = 13312;
    localparam int CLEAR_FRAMES = 180;
    localparam int RESTART_FRAMES = 45;

`ifdef GAME_LOOP_CTRL_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pf = 1'b0;
    logic jump = 1'b0;
    logic pause_req = 1'b0;
    logic [HIT_W-1:0] hit = '0;

    logic          upd  [2];
    logic [TW-1:0] tmr  [2];
    logic [1:0]    st   [2];
    logic [14:0]   spd  [2];
    logic          strt [2];
    logic          hobs [2];
    logic          grst [2];
    logic          rngl [2];

    int n_vec = 0;
    int n_miss = 0;
    int upd_cnt = 0;

    int p_init [2] = '{6144, 13310};
    int p_acc  [2] = '{1, 4};

    // Model: game phase, number of speed steps taken since the last (re)start, updates seen since crash.
    int m_state [2];
    int m_timer [2];
    int m_steps [2];
    int m_crash_upd [2];
    bit m_pfl [2];
    bit m_upd [2];
    bit m_start [2];
    bit m_rng [2];
    bit m_grst [2];

    always #5 clk = ~clk;

    game_loop_ctrl dut (
        .clk(clk), .rst(rst), .painter_finished(pf), .jump(jump), .pause_req(pause_req), .hit(hit),
        .update(upd[0]), .timer(tmr[0]), .state(st[0]), .speed(spd[0]), .start(strt[0]),
        .has_obstacles(hobs[0]), .game_reset(grst[0]), .rng_load(rngl[0])
    );

    game_loop_ctrl #(.SPEED_INIT(13310), .ACCEL(4)) dut_hi (
        .clk(clk), .rst(rst), .painter_finished(pf), .jump(jump), .pause_req(pause_req), .hit(hit),
        .update(upd[1]), .timer(tmr[1]), .state(st[1]), .speed(spd[1]), .start(strt[1]),
        .has_obstacles(hobs[1]), .game_reset(grst[1]), .rng_load(rngl[1])
    );

    task automatic chk(string tag, longint obs, longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint exp_speed(int i);
        longint s;
        if (!m_start[i]) return 0;
        s = longint'(p_init[i]) + longint'(p_acc[i]) * longint'(m_steps[i]);
        return (s > SPEED_MAX) ? SPEED_MAX : s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_timer[i] = 0; m_steps[i] = 0; m_crash_upd[i] = 0;
            m_pfl[i] = 0; m_upd[i] = 0; m_start[i] = 0; m_rng[i] = 1; m_grst[i] = 0;
        end
    endtask

    task automatic model_step(int i);
        bit edge_seen;
        bit tick;
        int ns;
        edge_seen = pf && !m_pfl[i];
        tick = edge_seen && !(PAUSE_ON && m_state[i] == 3);
        ns = m_state[i];
        m_grst[i] = 0;
        case (m_state[i])
            0: if (m_upd[i] && jump) begin
                ns = 1; m_start[i] = 1; m_rng[i] = 0; m_steps[i] = 0;
            end
            1: if (hit != '0) begin
                ns = 2; m_crash_upd[i] = 0;
            end else if (m_upd[i] && PAUSE_ON && pause_req) begin
                ns = 3;
            end else if (m_upd[i]) begin
                m_steps[i]++;
            end
            2: if (m_upd[i]) begin
                m_crash_upd[i]++;
                if (m_crash_upd[i] >= RESTART_FRAMES && jump) begin
                    ns = 1; m_grst[i] = 1; m_steps[i] = 0; m_crash_upd[i] = 0;
                end
            end
            default: if (m_upd[i] && !pause_req) ns = 1;
        endcase
        m_state[i] = ns;
        if (tick) m_timer[i] = (m_timer[i] + 1) % FPS;
        m_pfl[i] = pf;
        m_upd[i] = edge_seen;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.update", i), upd[i], m_upd[i]);
            chk($sformatf("u%0d.timer", i), tmr[i], m_timer[i]);
            chk($sformatf("u%0d.state", i), st[i], m_state[i]);
            chk($sformatf("u%0d.speed", i), spd[i], exp_speed(i));
            chk($sformatf("u%0d.start", i), strt[i], m_start[i]);
            chk($sformatf("u%0d.has_obstacles", i), hobs[i], m_start[i] && (m_steps[i] > CLEAR_FRAMES));
            chk($sformatf("u%0d.game_reset", i), grst[i], m_grst[i]);
            chk($sformatf("u%0d.rng_load", i), rngl[i], m_rng[i]);
        end
    endtask

    task automatic cycle(bit p, bit j, bit pr, logic [HIT_W-1:0] h);
        pf = p; jump = j; pause_req = pr; hit = h;
        if (rst) begin
            model_step(0);
            model_step(1);
        end
        @(posedge clk);
        @(negedge clk);
        if (upd[0]) upd_cnt++;
        compare_all();
    endtask

    task automatic frame(bit j, bit pr, logic [HIT_W-1:0] h);
        cycle(1'b1, j, pr, h);
        cycle(1'b0, j, pr, h);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, '0);
        rst = 1'b1;
    endtask

    initial begin
        longint s0;
        longint t0;
        int gcount;
        bit pause_r;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Three frames in WAITING without jump.
        upd_cnt = 0;
        for (int k = 0; k < 3; k++) frame(1'b0, 1'b0, '0);
        chk("wait.update_pulses", upd_cnt, 3);
        chk("wait.timer", tmr[0], 3);
        chk("wait.state", st[0], 0);
        chk("wait.speed", spd[0], 0);
        chk("wait.rng_load", rngl[0], 1);

        // Start the run.
        frame(1'b1, 1'b0, '0);
        chk("start.state", st[0], 1);
        chk("start.speed", spd[0], 6144);
        chk("start.start", strt[0], 1);
        chk("start.rng_load", rngl[0], 0);
        chk("start.hi_speed", spd[1], 13310);

        for (int k = 0; k < 180; k++) frame(1'b0, 1'b0, '0);
        chk("clear180.has_obstacles", hobs[0], 0);
        frame(1'b0, 1'b0, '0);
        chk("clear181.has_obstacles", hobs[0], 1);
        chk("clear181.speed", spd[0], 6144 + 181);
        chk("ceiling.hi_speed", spd[1], 13312);

        // Pause window.
        frame(1'b0, 1'b1, '0);
        chk("pause.enter_state", st[0], PAUSE_ON ? 3 : 1);
        t0 = tmr[0];
        s0 = spd[0];
`ifdef GAME_LOOP_CTRL_PAUSE_EN
        for (int k = 0; k < 5; k++) frame(1'b0, 1'b1, 16'h0100);
        chk("pause.timer_frozen", tmr[0], t0);
        chk("pause.speed_frozen", spd[0], s0);
        chk("pause.state_held", st[0], 3);
`else
        for (int k = 0; k < 5; k++) frame(1'b0, 1'b1, '0);
        chk("nopause.timer", tmr[0], (t0 + 5) % FPS);
`endif
        frame(1'b0, 1'b0, '0);
        chk("pause.exit_state", st[0], 1);

        // Crash with update and pause in the same cycle.
        cycle(1'b1, 1'b0, 1'b0, '0);
        s0 = spd[0];
        cycle(1'b0, 1'b0, 1'b1, 16'h0040);
        chk("crash.state", st[0], 2);
        chk("crash.speed", spd[0], s0);

        for (int k = 1; k <= 9; k++) frame(1'b0, 1'b0, '0);
        frame(1'b1, 1'b0, '0);
        chk("cool10.state", st[0], 2);
        for (int k = 11; k <= 44; k++) frame(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("restart.state", st[0], 1);
        chk("restart.game_reset", grst[0], 1);
        chk("restart.speed", spd[0], 6144);
        chk("restart.has_obstacles", hobs[0], 0);
        chk("restart.start", strt[0], 1);
        gcount = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            if (grst[0]) gcount++;
        end
        chk("restart.pulse_width", gcount, 0);

        // Random play with one asynchronous reset in the middle.
        pause_r = 1'b0;
        for (int c = 0; c < 24000; c++) begin
            logic [HIT_W-1:0] h;
            if (c == 12000) async_reset();
            if ($urandom_range(0, 31) == 0) pause_r = ~pause_r;
            h = ($urandom_range(0, 1499) == 0) ? (HIT_W'(1) << $urandom_range(0, HIT_W - 1)) : '0;
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), pause_r, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
